// File: rtl/mem_stall_pkg.sv
// Shared types and constants for the stalling req/gnt memory responder.
package mem_stall_pkg;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [DW-1:0] strb_t;

  // Right-shifting Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LfsrPoly = 16'hB400;

  typedef enum logic {IDLE, WAIT} stall_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
  endfunction
endpackage

// File: rtl/mem_stall_responder_lfsr16.sv
// 16-bit Galois LFSR that advances only when enabled.
module lfsr16
  import mem_stall_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);
  logic [15:0] r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   r_state <= Seed;
    else if (en_i) r_state <= lfsr_next(r_state);
  end

  assign state_o = r_state;
endmodule

// File: rtl/mem_stall_responder.sv
// req/gnt responder in front of an SRAM word port: injects bounded random
// grant stalls, tracks statistics and flags initiator protocol violations.
module mem_stall_responder
  import mem_stall_pkg::*;
#(
  parameter int          AddrWidth = 32,
  parameter int          DataWidth = 32,
  parameter logic [15:0] LfsrSeed  = 16'hACE1,
  parameter int          MaxStall  = 8,
  parameter int          CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [DataWidth-1:0] strb_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rvalid_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [DataWidth-1:0] mem_wmask_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 stall_en_i,
  input  logic [7:0]           stall_thresh_i,
  output logic [CntWidth-1:0]  xfer_cnt_o,
  output logic [CntWidth-1:0]  stall_cnt_o,
  output logic                 proto_err_o
);
  localparam int RunW = (MaxStall < 1) ? 1 : $clog2(MaxStall + 1);

  logic [15:0]          w_lfsr;
  logic                 w_unused_lfsr_hi;
  logic [RunW-1:0]      r_stall_run;
  logic                 w_stall_now, w_hs, w_stall_cyc;
  stall_state_e         r_state, w_state_nxt;
  logic                 w_capture, w_err_set, w_fields_chg;
  logic [AddrWidth-1:0] r_cap_addr;
  logic                 r_cap_we;
  logic [DataWidth-1:0] r_cap_wdata, r_cap_strb;
  logic                 r_proto_err, r_rvalid;
  logic [DataWidth-1:0] r_rdata_q;
  logic [CntWidth-1:0]  r_xfer_cnt, r_stall_cnt;

  lfsr16 #(.Seed(LfsrSeed)) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (req_i),
    .state_o (w_lfsr)
  );

  assign w_unused_lfsr_hi = ^w_lfsr[15:8];

  // Once the run hits MaxStall the pending request is granted regardless of the LFSR
  assign w_stall_now = stall_en_i & (w_lfsr[7:0] < stall_thresh_i)
                     & (r_stall_run < RunW'(MaxStall));
  assign gnt_o       = rst_ni & req_i & ~w_stall_now;
  assign w_hs        = req_i & gnt_o;
  assign w_stall_cyc = req_i & ~gnt_o;

  assign mem_req_o   = w_hs;
  assign mem_we_o    = we_i;
  assign mem_addr_o  = addr_i >> 2;
  assign mem_wdata_o = wdata_i;
  assign mem_wmask_o = strb_i;

  assign w_fields_chg = ({addr_i, we_i, wdata_i, strb_i}
                      != {r_cap_addr, r_cap_we, r_cap_wdata, r_cap_strb});

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_stall_cyc) begin
          w_state_nxt = WAIT;
          w_capture   = 1'b1;
        end
      end
      WAIT: begin
        if (!req_i) begin
          w_err_set   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_err_set = w_fields_chg;
          if (w_hs) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_stall_run <= '0;
      r_cap_addr  <= '0;
      r_cap_we    <= 1'b0;
      r_cap_wdata <= '0;
      r_cap_strb  <= '0;
      r_proto_err <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata_q   <= '0;
      r_xfer_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_run <= w_stall_cyc ? r_stall_run + 1'b1 : '0;
      if (w_capture) begin
        r_cap_addr  <= addr_i;
        r_cap_we    <= we_i;
        r_cap_wdata <= wdata_i;
        r_cap_strb  <= strb_i;
      end
      if (w_err_set) r_proto_err <= 1'b1;
      r_rvalid <= w_hs & ~we_i;
      if (r_rvalid) r_rdata_q <= mem_rdata_i;
      if (w_hs && r_xfer_cnt != '1)         r_xfer_cnt  <= r_xfer_cnt + 1'b1;
      if (w_stall_cyc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Read data shows the live SRAM word in the rvalid cycle, then the held copy
  assign rdata_o     = r_rvalid ? mem_rdata_i : r_rdata_q;
  assign rvalid_o    = r_rvalid;
  assign xfer_cnt_o  = r_xfer_cnt;
  assign stall_cnt_o = r_stall_cnt;
  assign proto_err_o = r_proto_err;
endmodule

// File: tb/tb_mem_stall_responder.sv
// Randomized and directed check of mem_stall_responder against a cycle-level reference model.
module tb_mem_stall_responder;
  localparam int MAXS = 8;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        req_i, we_i, stall_en_i;
  logic [31:0] addr_i, wdata_i, strb_i, mem_rdata_i;
  logic [7:0]  stall_thresh_i;
  logic        gnt_o, rvalid_o, mem_req_o, mem_we_o, proto_err_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_wmask_o, xfer_cnt_o, stall_cnt_o;

  mem_stall_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .wdata_i(wdata_i), .strb_i(strb_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
    .stall_en_i(stall_en_i), .stall_thresh_i(stall_thresh_i), .xfer_cnt_o(xfer_cnt_o),
    .stall_cnt_o(stall_cnt_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;

  // Reference model: LFSR value, current stall run length, pending-request record
  logic [15:0] m_lfsr;
  int          m_run;
  longint      m_xfer, m_stc;
  bit          m_rv, m_err, m_wait, m_gnt;
  logic [31:0] m_rdq, c_addr, c_wdata, c_strb;
  logic        c_we;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_run = 0; m_xfer = 0; m_stc = 0;
    m_rv = 0; m_err = 0; m_wait = 0; m_gnt = 0; m_rdq = '0;
  endtask

  task automatic reset_checks();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_xfer", xfer_cnt_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    chk("rst_err", proto_err_o, 0);
    chk("rst_lfsr", dut.u_lfsr.state_o, 16'hACE1);
  endtask

  // Called at posedge+1 with inputs set; checks at the negedge
  task automatic sample();
    bit stall;
    mem_rdata_i = $urandom();
    #4;
    stall = stall_en_i && (m_lfsr[7:0] < stall_thresh_i) && (m_run < MAXS);
    m_gnt = req_i && !stall;
    chk("gnt", gnt_o, m_gnt);
    chk("mem_req", mem_req_o, m_gnt);
    chk("mem_addr", mem_addr_o, {2'b00, addr_i[31:2]});
    chk("mem_we", mem_we_o, we_i);
    chk("mem_wdata", mem_wdata_o, wdata_i);
    chk("mem_wmask", mem_wmask_o, strb_i);
    chk("rvalid", rvalid_o, m_rv);
    chk("rdata", rdata_o, m_rv ? mem_rdata_i : m_rdq);
    chk("xfer_cnt", xfer_cnt_o, m_xfer);
    chk("stall_cnt", stall_cnt_o, m_stc);
    chk("proto_err", proto_err_o, m_err);
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (m_rv) m_rdq = mem_rdata_i;
    m_rv = m_gnt && !we_i;
    if (m_gnt && m_xfer < 64'hFFFF_FFFF) m_xfer++;
    if (req_i && !m_gnt) begin m_stc++; m_run++; end else m_run = 0;
    if (m_wait) begin
      if (!req_i) m_err = 1;
      else if (addr_i !== c_addr || we_i !== c_we || wdata_i !== c_wdata || strb_i !== c_strb) m_err = 1;
      if (!req_i || m_gnt) m_wait = 0;
    end else if (req_i && !m_gnt) begin
      m_wait = 1; c_addr = addr_i; c_we = we_i; c_wdata = wdata_i; c_strb = strb_i;
    end
    if (req_i) m_lfsr = lstep(m_lfsr);
    #1;
  endtask

  task automatic scen_basic_read();
    stall_en_i = 0; req_i = 1; we_i = 0; addr_i = 32'h8000_0010;
    sample();
    chk("s1_gnt", gnt_o, 1);
    chk("s1_maddr", mem_addr_o, 32'h2000_0004);
    advance();
    req_i = 0;
    sample();
    chk("s1_rvalid", rvalid_o, 1);
    chk("s1_rdata", rdata_o, mem_rdata_i);
    chk("s1_xfer", xfer_cnt_o, 1);
    advance();
  endtask

  initial begin
    logic [31:0] rdprev, d3;
    longint xb, sb;
    int n;
    bit done, saw255, stalled;

    model_reset();
    req_i = 1; we_i = 0; addr_i = 0; wdata_i = 0; strb_i = 0; mem_rdata_i = 0;
    stall_en_i = 0; stall_thresh_i = 0;
    @(posedge clk_i); #5;
    reset_checks();
    @(posedge clk_i); #1;
    rst_ni = 1; req_i = 0;
    sample(); advance();

    scen_basic_read();

    // Forced stall run: threshold 255 holds off grant for MaxStall cycles
    stall_en_i = 1; stall_thresh_i = 8'hFF; req_i = 1; we_i = 0; addr_i = 32'h100;
    n = 0; done = 0; saw255 = 0; sb = m_stc;
    for (int k = 0; k < 20 && !done; k++) begin
      if (m_lfsr[7:0] == 8'hFF) saw255 = 1;
      sample();
      if (gnt_o) done = 1; else n++;
      advance();
    end
    chk("stall_granted", done, 1);
    if (!saw255) chk("stall_len", n, MAXS);
    chk("stall_cnt_delta", stall_cnt_o - sb[31:0], n);
    req_i = 0; stall_en_i = 0;
    sample(); rdprev = mem_rdata_i;
    chk("stall_rvalid", rvalid_o, 1);
    chk("stall_err", proto_err_o, 0);
    advance();

    // Write: mask passes through, no rvalid, read data held
    req_i = 1; we_i = 1; addr_i = 32'h40; wdata_i = 32'hDEAD_BEEF; strb_i = 32'h0000_FFFF;
    sample();
    chk("wr_wmask", mem_wmask_o, 32'h0000_FFFF);
    chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("wr_mem_we", mem_we_o, 1);
    advance();
    req_i = 0; we_i = 0;
    sample();
    chk("wr_rvalid", rvalid_o, 0);
    chk("wr_rdata_hold", rdata_o, rdprev);
    advance();

    // Four back-to-back reads
    xb = m_xfer;
    req_i = 1; we_i = 0;
    for (int i = 0; i < 4; i++) begin
      addr_i = 32'h1000 + 32'(4 * i);
      sample();
      if (i > 0) chk("b2b_rvalid", rvalid_o, 1);
      advance();
    end
    req_i = 0;
    sample(); d3 = mem_rdata_i;
    chk("b2b_rvalid4", rvalid_o, 1);
    advance();
    sample();
    chk("b2b_hold", rdata_o, d3);
    chk("b2b_rvalid_off", rvalid_o, 0);
    chk("b2b_xfer", xfer_cnt_o, xb + 4);
    advance();

    // Random traffic from a well-behaved initiator
    for (int c = 0; c < 400; c++) begin
      if (!m_wait) begin
        req_i = ($urandom_range(3) != 0); we_i = $urandom_range(1);
        addr_i = $urandom(); wdata_i = $urandom(); strb_i = $urandom();
        stall_en_i = ($urandom_range(3) != 0);
        stall_thresh_i = 8'($urandom_range(255));
      end
      sample(); advance();
    end
    req_i = 0;
    sample();
    chk("rand_err_clean", proto_err_o, 0);
    advance();

    // Violation: drop request while stalled
    stall_en_i = 1; stall_thresh_i = 8'hFF; req_i = 1; we_i = 0; addr_i = 32'h200;
    stalled = 0;
    for (int k = 0; k < 10 && !stalled; k++) begin
      sample();
      if (!gnt_o) stalled = 1;
      advance();
    end
    chk("drop_stall_seen", stalled, 1);
    req_i = 0;
    sample(); advance();
    sample();
    chk("err_drop", proto_err_o, 1);
    advance();
    stall_en_i = 0; req_i = 1;
    for (int k = 0; k < 3; k++) begin sample(); advance(); end
    req_i = 0;
    sample();
    chk("err_sticky", proto_err_o, 1);
    advance();

    // Reset, then address change while waiting, then reset while in WAIT
    #1 rst_ni = 0; model_reset();
    @(posedge clk_i); #1; rst_ni = 1;
    stall_en_i = 1; stall_thresh_i = 8'hFF; req_i = 1; addr_i = 32'h300;
    stalled = 0;
    for (int k = 0; k < 10 && !stalled; k++) begin
      sample();
      if (!gnt_o) stalled = 1;
      advance();
    end
    chk("chg_stall_seen", stalled, 1);
    addr_i = 32'h304;
    sample(); advance();
    sample();
    chk("err_addr_chg", proto_err_o, 1);
    #1 rst_ni = 0;
    #1 reset_checks();
    model_reset();
    @(posedge clk_i); #1;
    req_i = 0; rst_ni = 1;
    sample();
    chk("post_rst_gnt", gnt_o, 0);
    advance();
    scen_basic_read();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
